// File: rtl/ripple_carry_adder_64.sv
// Ripple-carry adder: WIDTH full-adder cells chained bit 0 -> bit WIDTH-1,
// with sum and carry-out captured in an output register every clock.

module full_adder_cell (
  input  logic a,
  input  logic b,
  input  logic c_in,
  output logic s,
  output logic c_out
);

  logic p;

  assign p     = a ^ b;
  assign s     = p ^ c_in;
  assign c_out = (a & b) | (c_in & p);

endmodule

module ripple_carry_adder_64 #(
  parameter int unsigned WIDTH = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  output logic [WIDTH-1:0] sum,
  output logic             c_out
);

  logic [WIDTH-1:0] s;
  logic             carry_last;

  // Each cell owns its carry-out; the next cell reads it from the previous block.
  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    logic carry_in;
    logic carry;

    if (i == 0) begin : g_first
      assign carry_in = c_in;
    end else begin : g_chain
      assign carry_in = g_bit[i-1].carry;
    end

    full_adder_cell u_cell (
      .a     (a[i]),
      .b     (b[i]),
      .c_in  (carry_in),
      .s     (s[i]),
      .c_out (carry)
    );
  end

  assign carry_last = g_bit[WIDTH-1].carry;

  // Output register; reset clears the result without waiting for a clock edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sum   <= '0;
      c_out <= 1'b0;
    end else begin
      sum   <= s;
      c_out <= carry_last;
    end
  end

endmodule

// File: tb/tb_ripple_carry_adder_64.sv
// Bench for ripple_carry_adder_64: directed vector table, hand-written reset and
// latency sequences, and random operands against a 65-bit arithmetic model.

module tb_ripple_carry_adder_64;

  logic        clk;
  logic        rst;
  logic [63:0] a;
  logic [63:0] b;
  logic        c_in;
  logic [63:0] sum;
  logic        c_out;

  int n_vec;
  int n_err;

  ripple_carry_adder_64 #(.WIDTH(64)) dut (
    .clk   (clk),
    .rst   (rst),
    .a     (a),
    .b     (b),
    .c_in  (c_in),
    .sum   (sum),
    .c_out (c_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [63:0] a;
    logic [63:0] b;
    logic        c_in;
    logic [63:0] exp_sum;
    logic        exp_cout;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [63:0] es, input logic ec);
    n_vec++;
    if (sum !== es || c_out !== ec) begin
      n_err++;
      $display("FAIL %s: got sum=%h c_out=%b, expected sum=%h c_out=%b",
               name, sum, c_out, es, ec);
    end
  endtask

  // Inputs change just after a rising edge; results are sampled 1 time unit after the next one.
  task automatic apply(input logic [63:0] va, input logic [63:0] vb, input logic vc);
    a    = va;
    b    = vb;
    c_in = vc;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [64:0] ref_add(input logic [63:0] x, input logic [63:0] y,
                                          input logic ci);
    return 65'(x) + 65'(y) + 65'(ci);
  endfunction

  initial begin
    logic [64:0] r;
    logic [63:0] ra;
    logic [63:0] rb;
    logic        rc;

    n_vec = 0;
    n_err = 0;
    rst   = 1'b0;
    a     = 64'd5;
    b     = 64'd6;
    c_in  = 1'b0;

    vecs.push_back('{"basic_ff_12",  64'hFF, 64'h12, 1'b0, 64'h111, 1'b0});
    vecs.push_back('{"full_ripple",  64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1'b1, 64'h0, 1'b1});
    vecs.push_back('{"wrap_max_1",   64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 64'h0, 1'b1});
    vecs.push_back('{"wrap_msb",     64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0, 64'h0, 1'b1});
    vecs.push_back('{"no_carry",     64'hAAAA_AAAA_AAAA_AAAA, 64'h5555_5555_5555_5555, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0});
    vecs.push_back('{"no_carry_cin", 64'hAAAA_AAAA_AAAA_AAAA, 64'h5555_5555_5555_5555, 1'b1, 64'h0, 1'b1});
    vecs.push_back('{"b2b_1_1",      64'd1, 64'd1, 1'b0, 64'd2, 1'b0});
    vecs.push_back('{"b2b_2_3",      64'd2, 64'd3, 1'b0, 64'd5, 1'b0});
    vecs.push_back('{"b2b_7_7",      64'd7, 64'd7, 1'b0, 64'd14, 1'b0});
    vecs.push_back('{"zero_cin",     64'd0, 64'd0, 1'b1, 64'd1, 1'b0});

    // Capture a nonzero result first so the reset clear is observable.
    @(posedge clk);
    #1;
    check("pre_reset_capture", 64'd11, 1'b0);

    // Reset asserted between edges clears outputs immediately and holds them.
    #1;
    rst = 1'b1;
    a   = 64'hDEAD;
    b   = 64'h1;
    #1;
    check("reset_immediate", 64'h0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    check("reset_held", 64'h0, 1'b0);
    #2;
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("reset_release", 64'hDEAE, 1'b0);

    // Output keeps the previous result until the next edge.
    a    = 64'hFF;
    b    = 64'h12;
    c_in = 1'b0;
    #2;
    check("latency_hold", 64'hDEAE, 1'b0);
    @(posedge clk);
    #1;
    check("latency_update", 64'h111, 1'b0);

    foreach (vecs[i]) begin
      apply(vecs[i].a, vecs[i].b, vecs[i].c_in);
      check(vecs[i].name, vecs[i].exp_sum, vecs[i].exp_cout);
    end

    // Reset mid-stream discards the pending result.
    a    = 64'd100;
    b    = 64'd200;
    c_in = 1'b1;
    #2;
    rst = 1'b1;
    #1;
    check("midstream_reset", 64'h0, 1'b0);
    @(posedge clk);
    #1;
    check("midstream_reset_edge", 64'h0, 1'b0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("midstream_release", 64'd301, 1'b0);

    for (int k = 0; k < 10000; k++) begin
      ra = {$urandom, $urandom};
      rb = {$urandom, $urandom};
      rc = 1'($urandom_range(1, 0));
      if (k % 16 == 0) ra = ~rb;
      r = ref_add(ra, rb, rc);
      apply(ra, rb, rc);
      check("random", r[63:0], r[64]);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/ripple_carry_adder_64.md
Name: ripple_carry_adder_64

Overview:
64-bit ripple-carry adder with registered outputs, used as the baseline adder in the 64-bit adder comparison datapath. Computes a + b + c_in through a chain of 1-bit full adders, with carry rippling from bit 0 to bit 63. Sum and carry-out are captured in an output register on each clock edge. One clock; reset is asynchronous and active-high.

Parameters:
- WIDTH, 64, operand and sum width in bits. The block is verified only at 64; other values must elaborate but are unsupported.

Ports:
- clk  input  1  system clock; the output register updates on the rising edge.
- rst  input  1  asynchronous, active-high reset; clears the output registers.
- a  input  64  operand A, unsigned.
- b  input  64  operand B, unsigned.
- c_in  input  1  carry into bit 0.
- sum  output  64  registered (a + b + c_in) mod 2^64.
- c_out  output  1  registered carry out of bit 63.

Behaviour:
- Datapath structure:
  - Combinational chain of 64 full-adder cells.
  - Cell i: s[i] = a[i] ^ b[i] ^ c[i]; c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i])).
  - c[0] = c_in; c[64] is the carry-out.
  - No carry-lookahead, carry-select or other acceleration. The carry must ripple cell-to-cell.
  - The full-adder cell is a separate submodule, instantiated 64 times with a generate loop.
- Output register:
  - On each rising clk edge with rst low: sum <= s[63:0] and c_out <= c[64].
  - Latency is exactly 1 cycle from input change to visible output. There is no enable, and a new result is captured every cycle.
- Arithmetic:
  - Unsigned modular addition: {c_out, sum} = a + b + c_in, 65 bits total.
  - No saturation.
  - No signed overflow flag; the consumer derives it if needed.
- Reset:
  - rst high forces sum = 0 and c_out = 0 immediately, without waiting for clk.
  - Outputs stay 0 while rst is held.
  - On the first rising edge after rst deasserts, the current inputs are captured.
  - Reset asserted mid-operation discards the pending result; nothing is retained.
- Inputs are sampled only at the clock edge. Input glitches between edges have no effect on the outputs.
- X/Z on the inputs is not handled specially and propagates.
- Timing: the critical path is the full 64-cell carry chain plus the register setup time. The operating frequency is chosen accordingly; the block is not pipelined.

Test Plan:
- Reset: assert rst with arbitrary inputs (a=64'hDEAD, b=1) -> sum=0, c_out=0 immediately and while held. Deassert rst; after 1 edge -> sum=64'hDEAE, c_out=0.
- Basic add: a=64'hFF, b=64'h12, c_in=0 -> one cycle later sum=64'h111, c_out=0. The output before that edge still holds the previous value.
- Full-length carry ripple: a=64'hFFFF_FFFF_FFFF_FFFF, b=0, c_in=1 -> sum=0, c_out=1.
- Overflow wrap: a=64'hFFFF_FFFF_FFFF_FFFF, b=64'h1, c_in=0 -> sum=0, c_out=1. Then a=b=64'h8000_0000_0000_0000, c_in=0 -> sum=0, c_out=1.
- No-carry pattern: a=64'hAAAA_AAAA_AAAA_AAAA, b=64'h5555_5555_5555_5555, c_in=0 -> sum=64'hFFFF_FFFF_FFFF_FFFF, c_out=0. The same operands with c_in=1 -> sum=0, c_out=1.
- Back-to-back and reset mid-stream:
  - Apply a new operand pair every cycle (e.g. 1+1, 2+3, 7+7) -> outputs 2, 5, 14 on consecutive cycles.
  - Assert rst between edges -> outputs go to 0 without a clock edge.
  - Check 10k random a, b, c_in against the 65-bit reference sum at 1-cycle latency.
